// File: rtl/num_render.sv
// Four-digit score overlay: double-dabble BCD conversion of a latched score,
// plus a three-stage pixel pipeline that keys digit-ROM images over the background.
module num_render #(
  parameter logic [9:0]  X0    = 10'd160,
  parameter logic [9:0]  Y0    = 10'd180,
  parameter int          DIG_W = 80,
  parameter int          DIG_H = 120,
  parameter logic [11:0] KEY   = 12'h000
) (
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        frame_start,
  input  logic [13:0] score,
  input  logic [11:0] bg_pixel,
  output logic [16:0] addr,
  output logic [3:0]  num,
  input  logic [11:0] pixel,
  output logic [11:0] pixel_out,
  output logic        pixel_vld,
  output logic        busy
);

  localparam logic [10:0] XB0 = {1'b0, X0};
  localparam logic [10:0] XB1 = 11'(int'(X0) + DIG_W);
  localparam logic [10:0] XB2 = 11'(int'(X0) + 2 * DIG_W);
  localparam logic [10:0] XB3 = 11'(int'(X0) + 3 * DIG_W);
  localparam logic [10:0] XE  = 11'(int'(X0) + 4 * DIG_W);
  localparam logic [10:0] YB0 = {1'b0, Y0};
  localparam logic [10:0] YE  = 11'(int'(Y0) + DIG_H);

  typedef enum logic {IDLE, CONV} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [13:0]      bin_q, bin_d;
  logic [3:0][3:0]  bcd_q, bcd_d, adj, digits_q;
  logic [29:0]      shifted;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (adj[i] >= 4'd5) adj[i] = adj[i] + 4'd3;
    end
    shifted = {adj, bin_q} << 1;
    bcd_d   = shifted[29:14];
    bin_d   = shifted[13:0];
  end

  // Display digits only change on the edge that ends the 14th shift.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      digits_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            bin_q   <= (score > 14'd9999) ? 14'd9999 : score;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            state_q  <= IDLE;
            digits_q <= bcd_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == CONV);

  logic [10:0] hx, vy, base;
  logic [1:0]  c_d;
  logic        in_d;
  logic [9:0]  lx_d, ly_d;

  always_comb begin
    hx   = {1'b0, h_cnt};
    vy   = {1'b0, v_cnt};
    in_d = valid && (hx >= XB0) && (hx < XE) && (vy >= YB0) && (vy < YE);
    if (hx >= XB3) begin
      c_d = 2'd3; base = XB3;
    end else if (hx >= XB2) begin
      c_d = 2'd2; base = XB2;
    end else if (hx >= XB1) begin
      c_d = 2'd1; base = XB1;
    end else begin
      c_d = 2'd0; base = XB0;
    end
    lx_d = 10'(hx - base);
    ly_d = 10'(vy - YB0);
  end

  logic        in1_q, vld1_q;
  logic [1:0]  c1_q;
  logic [9:0]  lx1_q, ly1_q;
  logic [11:0] bg1_q;

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      in1_q  <= 1'b0;
      vld1_q <= 1'b0;
      c1_q   <= '0;
      lx1_q  <= '0;
      ly1_q  <= '0;
      bg1_q  <= '0;
    end else begin
      in1_q  <= in_d;
      vld1_q <= valid;
      c1_q   <= c_d;
      lx1_q  <= lx_d;
      ly1_q  <= ly_d;
      bg1_q  <= bg_pixel;
    end
  end

  // Cell 0 is the leftmost (thousands) digit; leading zeros are blanked.
  logic [1:0]  msd, dsel;
  logic        blank_d;
  logic [16:0] addr_d;
  logic [3:0]  num_d;

  always_comb begin
    if (digits_q[3] != 4'd0)      msd = 2'd3;
    else if (digits_q[2] != 4'd0) msd = 2'd2;
    else if (digits_q[1] != 4'd0) msd = 2'd1;
    else                          msd = 2'd0;
    dsel    = 2'd3 - c1_q;
    blank_d = (dsel > msd);
    addr_d  = in1_q ? (17'(ly1_q) * 17'(DIG_W) + 17'(lx1_q)) : '0;
    num_d   = in1_q ? digits_q[dsel] : '0;
  end

  logic        in2_q, blank2_q, vld2_q;
  logic [16:0] addr_q;
  logic [3:0]  num_q;
  logic [11:0] bg2_q;
  logic        in3_q, blank3_q, vld3_q;
  logic [11:0] bg3_q;

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      num_q    <= '0;
      in2_q    <= 1'b0;
      blank2_q <= 1'b0;
      vld2_q   <= 1'b0;
      bg2_q    <= '0;
      in3_q    <= 1'b0;
      blank3_q <= 1'b0;
      vld3_q   <= 1'b0;
      bg3_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      num_q    <= num_d;
      in2_q    <= in1_q;
      blank2_q <= blank_d;
      vld2_q   <= vld1_q;
      bg2_q    <= bg1_q;
      in3_q    <= in2_q;
      blank3_q <= blank2_q;
      vld3_q   <= vld2_q;
      bg3_q    <= bg2_q;
    end
  end

  // The ROM register is the third stage, so its data is combined with the
  // stage-3 registers directly to keep the three-cycle pixel latency.
  assign addr      = addr_q;
  assign num       = num_q;
  assign pixel_vld = vld3_q;
  assign pixel_out = !vld3_q ? 12'h000 :
                     (in3_q && !blank3_q && (pixel != KEY)) ? pixel : bg3_q;

endmodule

// File: tb/tb_num_render.sv
// Self-checking bench for num_render: random pixel streams against an
// arithmetic reference model, plus directed conversion/reset scenarios.
module tb_num_render;

  localparam int          X0    = 160;
  localparam int          Y0    = 180;
  localparam int          DIG_W = 80;
  localparam int          DIG_H = 120;
  localparam logic [11:0] KEY   = 12'h000;

  logic        clk_25m = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic        valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [13:0] score = '0;
  logic [11:0] bg_pixel = '0;
  logic [16:0] addr;
  logic [3:0]  num;
  logic [11:0] pixel = '0;
  logic [11:0] pixel_out;
  logic        pixel_vld;
  logic        busy;

  int total = 0;
  int bad = 0;
  int dispVal = 0;

  typedef struct {
    int          h;
    int          v;
    bit          vld;
    logic [11:0] bg;
  } stim_t;

  num_render #(
    .X0(10'(X0)), .Y0(10'(Y0)), .DIG_W(DIG_W), .DIG_H(DIG_H), .KEY(KEY)
  ) dut (
    .clk_25m(clk_25m), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .valid(valid), .frame_start(frame_start), .score(score),
    .bg_pixel(bg_pixel), .addr(addr), .num(num), .pixel(pixel),
    .pixel_out(pixel_out), .pixel_vld(pixel_vld), .busy(busy)
  );

  always #20 clk_25m = ~clk_25m;

  function automatic logic [11:0] romFn(input logic [16:0] a, input logic [3:0] n);
    if ((a % 7) == 3) return KEY;
    return {n, a[7:0]} ^ 12'h5A5;
  endfunction

  // Registered digit ROM: data appears one cycle after addr/num.
  always @(posedge clk_25m) pixel <= romFn(addr, num);

  function automatic int digitOf(input int d, input int i);
    return (d / (10 ** i)) % 10;
  endfunction

  function automatic int digitCount(input int d);
    if (d >= 1000) return 4;
    if (d >= 100)  return 3;
    if (d >= 10)   return 2;
    return 1;
  endfunction

  function automatic bit inStrip(input stim_t s);
    return s.vld && s.h >= X0 && s.h < X0 + 4 * DIG_W && s.v >= Y0 && s.v < Y0 + DIG_H;
  endfunction

  function automatic int expAddr(input stim_t s);
    if (!inStrip(s)) return 0;
    return (s.v - Y0) * DIG_W + (s.h - X0) % DIG_W;
  endfunction

  function automatic int expNum(input stim_t s, input int d);
    if (!inStrip(s)) return 0;
    return digitOf(d, 3 - (s.h - X0) / DIG_W);
  endfunction

  function automatic int expPix(input stim_t s, input int d);
    logic [11:0] rp;
    bit shown;
    if (!s.vld) return 0;
    shown = inStrip(s) && ((3 - (s.h - X0) / DIG_W) < digitCount(d));
    rp = romFn(17'(expAddr(s)), 4'(expNum(s, d)));
    if (shown && rp != KEY) return int'(rp);
    return int'(s.bg);
  endfunction

  function automatic stim_t boundaryStim(input int i);
    stim_t s;
    s.vld = 1'b1;
    s.bg  = 12'(12'h321 + i);
    case (i)
      0:  begin s.h = X0;                 s.v = Y0;             end
      1:  begin s.h = X0 + DIG_W - 1;     s.v = Y0;             end
      2:  begin s.h = X0 + DIG_W;         s.v = Y0 + 2;         end
      3:  begin s.h = X0 + DIG_W + 5;     s.v = Y0 + 2;         end
      4:  begin s.h = X0 + 2 * DIG_W;     s.v = Y0 + 50;        end
      5:  begin s.h = X0 + 3 * DIG_W;     s.v = Y0;             end
      6:  begin s.h = X0 + 4 * DIG_W - 1; s.v = Y0 + DIG_H - 1; end
      7:  begin s.h = X0 + 4 * DIG_W;     s.v = Y0 + 10;        end
      8:  begin s.h = X0 + 10;            s.v = Y0 + DIG_H;     end
      9:  begin s.h = X0 - 1;             s.v = Y0 + 10;        end
      default: begin s.h = X0 + 30;       s.v = Y0 + 30; s.vld = 1'b0; end
    endcase
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Streams n pixels (boundary points first, then random) against display value d.
  task automatic applyStimulus(input int n, input int d);
    stim_t q[$];
    stim_t s;
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk_25m);
      if (q.size() >= 3) begin
        s = q[q.size() - 3];
        checkOutput("pixel_out", 32'(pixel_out), 32'(expPix(s, d)));
        checkOutput("pixel_vld", 32'(pixel_vld), 32'(s.vld));
      end
      if (q.size() >= 2) begin
        s = q[q.size() - 2];
        checkOutput("addr", 32'(addr), 32'(expAddr(s)));
        checkOutput("num", 32'(num), 32'(expNum(s, d)));
      end
      if (i < 11) s = boundaryStim(i);
      else begin
        s.h   = $urandom_range(X0 - 20, X0 + 4 * DIG_W + 20);
        s.v   = $urandom_range(Y0 - 10, Y0 + DIG_H + 10);
        s.vld = ($urandom_range(0, 9) != 0);
        s.bg  = 12'($urandom_range(0, 4095));
      end
      if (i >= n) s.vld = 1'b0;
      h_cnt    = 10'(s.h);
      v_cnt    = 10'(s.v);
      valid    = s.vld;
      bg_pixel = s.bg;
      q.push_back(s);
    end
  endtask

  // Runs one conversion; optionally re-pulses frame_start or resets mid-way.
  task automatic runConversion(input int sc, input int glitchAt, input int resetAt);
    int busyCycles = 0;
    bit aborted = 0;
    int newVal = (sc > 9999) ? 9999 : sc;
    h_cnt = 10'(X0 + 3 * DIG_W + 1);
    v_cnt = 10'(Y0);
    valid = 1'b1;
    @(negedge clk_25m);
    score = 14'(sc);
    frame_start = 1'b1;
    @(negedge clk_25m);
    frame_start = 1'b0;
    for (int cyc = 1; cyc <= 40 && busy; cyc++) begin
      busyCycles = cyc;
      if (cyc >= 3) checkOutput("num_hold", 32'(num), 32'(digitOf(dispVal, 0)));
      if (cyc == resetAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_addr", 32'(addr), 32'(0));
        checkOutput("rst_num", 32'(num), 32'(0));
        checkOutput("rst_pixel_out", 32'(pixel_out), 32'(0));
        checkOutput("rst_pixel_vld", 32'(pixel_vld), 32'(0));
        #4 rst_n = 1'b1;
        aborted = 1;
        break;
      end
      score = 14'($urandom_range(0, 16383));
      frame_start = (cyc == glitchAt);
      @(negedge clk_25m);
    end
    frame_start = 1'b0;
    if (aborted) begin
      dispVal = 0;
    end else begin
      checkOutput("busy_cycles", 32'(busyCycles), 32'(14));
      checkOutput("num_at_fall", 32'(num), 32'(digitOf(dispVal, 0)));
      @(negedge clk_25m);
      checkOutput("num_after", 32'(num), 32'(digitOf(newVal, 0)));
      dispVal = newVal;
    end
  endtask

  initial begin
    #5 rst_n = 1'b0;
    #30;
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_addr", 32'(addr), 32'(0));
    checkOutput("reset_num", 32'(num), 32'(0));
    checkOutput("reset_pixel_out", 32'(pixel_out), 32'(0));
    checkOutput("reset_pixel_vld", 32'(pixel_vld), 32'(0));
    @(negedge clk_25m);
    rst_n = 1'b1;
    dispVal = 0;
    applyStimulus(30, dispVal);

    runConversion(1234, -1, -1);
    applyStimulus(80, dispVal);
    runConversion(12000, -1, -1);
    applyStimulus(60, dispVal);
    runConversion(7, -1, -1);
    applyStimulus(60, dispVal);
    runConversion(305, -1, -1);
    applyStimulus(60, dispVal);
    runConversion(4821, 5, -1);
    applyStimulus(40, dispVal);
    runConversion(5555, -1, 7);
    applyStimulus(40, dispVal);
    runConversion(42, -1, -1);
    applyStimulus(40, dispVal);
    for (int k = 0; k < 4; k++) begin
      runConversion(int'($urandom_range(0, 16383)), -1, -1);
      applyStimulus(60, dispVal);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/num_render.md
NUM_RENDER -- requirements
Module: num_render

Interface
REQ-001 Parameters (name, default, meaning): X0, 10'd160, left edge of the digit strip in pixels.
REQ-002 Y0, 10'd180, top edge of the digit strip in pixels.
REQ-003 DIG_W, 80, width of one digit image in pixels.
REQ-004 DIG_H, 120, height of one digit image in pixels.
REQ-005 KEY, 12'h000, transparent colour in digit images.
REQ-006 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-007 Ports (name, direction, width, meaning):
- clk_25m, in, 1, pixel clock.
- rst_n, in, 1, asynchronous active-low reset.
- h_cnt, in, 10, current pixel x.
- v_cnt, in, 10, current pixel y.
- valid, in, 1, h_cnt/v_cnt address the visible area.
- frame_start, in, 1, one-cycle pulse at start of frame.
- score, in, 14, binary value to display.
- bg_pixel, in, 12, background colour for the current h_cnt/v_cnt.
- addr, out, 17, digit-ROM address.
- num, out, 4, digit-ROM select (0-9).
- pixel, in, 12, digit-ROM data, registered, 1 cycle after addr/num.
- pixel_out, out, 12, composed RGB444 output.
- pixel_vld, out, 1, pixel_out qualifier.
- busy, out, 1, BCD conversion in progress.

Function
REQ-008 The strip SHALL be four digit cells, d3 (thousands, leftmost) to d0 (units), each DIG_W x DIG_H, spanning x in [X0, X0+4*DIG_W) and y in [Y0, Y0+DIG_H).
REQ-009 On frame_start with busy=0, the block SHALL latch min(score, 9999) and set busy=1 on the next edge.
REQ-010 The conversion SHALL be double-dabble: 14 shift cycles, with add-3 applied to any BCD nibble >=5 before each shift.
REQ-011 busy SHALL be high for exactly 14 cycles.
REQ-012 The display digit register (4x4 bits) SHALL update on the same edge that busy falls, and at no other time.
REQ-013 frame_start while busy=1 SHALL be ignored; the conversion in progress SHALL complete unaffected.
REQ-014 Changes on score outside a frame_start latch SHALL have no effect.
REQ-015 Pipeline stage 1, registered from the inputs, SHALL capture:
- in_strip: valid AND position inside the strip.
- Cell index c, found by comparisons against X0 + k*DIG_W (no divider).
- lx = h_cnt - X0 - c*DIG_W.
- ly = v_cnt - Y0.
- valid.
- bg_pixel.
REQ-016 Stage 2, registered, SHALL drive addr = ly*DIG_W + lx (17-bit, no truncation for the defaults) and num = display digit c. It SHALL delay in_strip, blank, valid and bg_pixel by one more cycle.
REQ-017 Stage 3 is the ROM cycle. pixel_out SHALL be a function of the stage-2 signals delayed one cycle and pixel, registered into the output: total latency 3 cycles from h_cnt/v_cnt to pixel_out.
REQ-018 Blanking: digits above the most significant nonzero digit SHALL be blank. A value of 0 SHALL show only d0.
REQ-019 Composition:
- If in_strip, not blank, and pixel != KEY, then pixel_out = pixel.
- Otherwise, pixel_out = the delayed bg_pixel.
REQ-020 pixel_vld SHALL equal valid delayed 3 cycles.
REQ-021 When pixel_vld=0, pixel_out SHALL be 12'h000.
REQ-022 Outside the strip, addr SHALL be 0 and num SHALL be 0 (ROM output is don't-care).
REQ-023 Pixels exactly at x = X0+k*DIG_W SHALL belong to cell k, with lx = 0.
REQ-024 x = X0+4*DIG_W and y = Y0+DIG_H SHALL be outside the strip.

Reset
REQ-025 On rst_n=0, the block SHALL asynchronously clear:
- All pipeline registers.
- addr=0, num=0, pixel_out=0, pixel_vld=0, busy=0.
- Display digits = 0000, showing "0".
REQ-026 Reset during conversion SHALL abort it; the display SHALL show 0 until the next complete conversion.
REQ-027 After rst_n rises, the first frame_start SHALL be honoured.

Verification
REQ-028 score=1234, frame_start pulse -> busy high 14 cycles; digits become 1,2,3,4 on its falling edge; num=1 at x=X0 and num=4 at x=X0+3*DIG_W.
REQ-029 score=12000 -> display 9999. score=7 -> cells d3..d1 show bg_pixel and d0 shows image 7.
REQ-030 h_cnt=X0+DIG_W+5, v_cnt=Y0+2, valid=1 -> addr=2*80+5=165 and num=d2, two cycles later; pixel_out = pixel (if not KEY) one cycle after that; pixel_vld high.
REQ-031 ROM model returns KEY inside the strip -> pixel_out equals the bg_pixel supplied 3 cycles earlier. valid=0 -> pixel_out=0 and pixel_vld=0.
REQ-032 Second frame_start at conversion cycle 5 is ignored. Changing score mid-conversion leaves the result equal to the latched value.
REQ-033 rst_n pulsed low at conversion cycle 7 -> busy=0 and all outputs 0 immediately; the display shows "0" until the next frame_start completes.
